// File: rtl/cross_bar_switch_tdest_pkg.sv
// Shared types and helpers for the tdest-routed AXI-Stream crossbar.
package cross_bar_pkg;

   localparam int MIN_CHANNEL_NO = 1;
   localparam int MAX_CHANNEL_NO = 32;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_BUSY = 1'b1
   } arb_state_t;

   // Index width for n items, never narrower than one bit.
   function automatic int clog2_safe(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w++;
      return w;
   endfunction

endpackage

// File: rtl/cross_bar_switch_tdest_rr_arbiter.sv
// Packet-level round-robin arbiter for one crossbar output: registered grant,
// held from arbitration until the granted input's tlast beat is accepted.
module cross_bar_rr_arbiter
   import cross_bar_pkg::*;
#(
   parameter int CHANNEL_NO  = 4,
   parameter int GRANT_WIDTH = clog2_safe(CHANNEL_NO)
) (
   input  logic                   aclk,
   input  logic                   areset,
   input  logic [CHANNEL_NO-1:0]  req,
   input  logic                   accept,
   input  logic                   last,
   output logic [GRANT_WIDTH-1:0] grant,
   output logic                   busy
);

   arb_state_t             state_reg;
   logic [GRANT_WIDTH-1:0] grant_reg;
   logic [GRANT_WIDTH-1:0] ptr_reg;
   logic [GRANT_WIDTH-1:0] sel_next;
   logic                   any_req;

   // First requester at or after the pointer, in cyclic order.
   always_comb begin
      int idx;
      sel_next = '0;
      any_req  = 1'b0;
      idx      = 0;
      for (int k = 0; k < CHANNEL_NO; k++) begin
         idx = int'(ptr_reg) + k;
         if (idx >= CHANNEL_NO) idx = idx - CHANNEL_NO;
         if (!any_req && req[idx]) begin
            any_req  = 1'b1;
            sel_next = GRANT_WIDTH'(idx);
         end
      end
   end

   always_ff @(posedge aclk or negedge areset) begin
      if (!areset) begin
         state_reg <= ARB_IDLE;
         grant_reg <= '0;
         ptr_reg   <= '0;
      end else begin
         case (state_reg)
            ARB_IDLE: begin
               if (any_req) begin
                  grant_reg <= sel_next;
                  state_reg <= ARB_BUSY;
               end
            end
            ARB_BUSY: begin
               if (accept && last) begin
                  state_reg <= ARB_IDLE;
                  ptr_reg   <= (int'(grant_reg) == CHANNEL_NO - 1) ? '0
                               : grant_reg + GRANT_WIDTH'(1);
               end
            end
            default: state_reg <= ARB_IDLE;
         endcase
      end
   end

   assign grant = grant_reg;
   assign busy  = (state_reg == ARB_BUSY);

endmodule

// File: rtl/cross_bar_switch_tdest.sv
// AXI-Stream crossbar: S inputs routed to M outputs by tdest, with one packet
// round-robin arbiter and one registered output stage per output.
module cross_bar_switch_tdest
   import cross_bar_pkg::*;
#(
   parameter int S_CHANNEL_NO = 4,
   parameter int M_CHANNEL_NO = 3,
   parameter int DATA_WIDTH   = 32,
   parameter int KEEP_WIDTH   = DATA_WIDTH / 8,
   parameter int DEST_WIDTH   = clog2_safe(M_CHANNEL_NO)
) (
   input  logic                                    aclk,
   input  logic                                    areset,
   input  logic [S_CHANNEL_NO-1:0][DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [S_CHANNEL_NO-1:0][KEEP_WIDTH-1:0] s_axis_tkeep,
   input  logic [S_CHANNEL_NO-1:0][DEST_WIDTH-1:0] s_axis_tdest,
   input  logic [S_CHANNEL_NO-1:0]                 s_axis_tvalid,
   input  logic [S_CHANNEL_NO-1:0]                 s_axis_tlast,
   output logic [S_CHANNEL_NO-1:0]                 s_axis_tready,
   output logic [M_CHANNEL_NO-1:0][DATA_WIDTH-1:0] m_axis_tdata,
   output logic [M_CHANNEL_NO-1:0][KEEP_WIDTH-1:0] m_axis_tkeep,
   output logic [M_CHANNEL_NO-1:0]                 m_axis_tvalid,
   output logic [M_CHANNEL_NO-1:0]                 m_axis_tlast,
   input  logic [M_CHANNEL_NO-1:0]                 m_axis_tready,
   output logic [S_CHANNEL_NO-1:0]                 s_drop
);

   localparam int GRANT_WIDTH = clog2_safe(S_CHANNEL_NO);

   if (S_CHANNEL_NO < MIN_CHANNEL_NO || S_CHANNEL_NO > MAX_CHANNEL_NO ||
       M_CHANNEL_NO < MIN_CHANNEL_NO || M_CHANNEL_NO > MAX_CHANNEL_NO) begin : g_bad_count
      $error("cross_bar_switch_tdest: channel count out of range");
   end

   logic [S_CHANNEL_NO-1:0]                   in_range;
   logic [S_CHANNEL_NO-1:0]                   drop_rdy;
   logic [S_CHANNEL_NO-1:0][DEST_WIDTH-1:0]   eff_dest;
   logic [S_CHANNEL_NO-1:0]                   ready_comb;
   logic [M_CHANNEL_NO-1:0][S_CHANNEL_NO-1:0] req;
   logic [M_CHANNEL_NO-1:0][GRANT_WIDTH-1:0]  grant;
   logic [M_CHANNEL_NO-1:0]                   busy;
   logic [M_CHANNEL_NO-1:0]                   out_rdy;
   logic [M_CHANNEL_NO-1:0]                   arb_accept;
   logic [M_CHANNEL_NO-1:0]                   sel_valid;
   logic [M_CHANNEL_NO-1:0]                   sel_last;
   logic [M_CHANNEL_NO-1:0][DATA_WIDTH-1:0]   sel_data;
   logic [M_CHANNEL_NO-1:0][KEEP_WIDTH-1:0]   sel_keep;

   genvar gi, gj;

   for (gi = 0; gi < S_CHANNEL_NO; gi++) begin : g_in
      logic                  head_reg;
      logic [DEST_WIDTH-1:0] dest_reg;
      logic                  accept;

      assign eff_dest[gi] = head_reg ? s_axis_tdest[gi] : dest_reg;
      assign in_range[gi] = 32'(eff_dest[gi]) < 32'(M_CHANNEL_NO);
      // A dropped packet keeps tready high between beats so it always drains.
      assign drop_rdy[gi] = !in_range[gi] && (s_axis_tvalid[gi] || !head_reg);
      assign s_drop[gi]   = areset && head_reg && s_axis_tvalid[gi] && !in_range[gi];
      assign accept       = s_axis_tvalid[gi] && s_axis_tready[gi];

      always_ff @(posedge aclk or negedge areset) begin
         if (!areset) begin
            head_reg <= 1'b1;
            dest_reg <= '0;
         end else if (accept) begin
            head_reg <= s_axis_tlast[gi];
            if (head_reg) dest_reg <= s_axis_tdest[gi];
         end
      end

      for (gj = 0; gj < M_CHANNEL_NO; gj++) begin : g_req
         assign req[gj][gi] = s_axis_tvalid[gi] && in_range[gi] &&
                              (32'(eff_dest[gi]) == 32'(gj));
      end
   end

   // Per-output beat select by grant; only the granted input sees tready.
   always_comb begin
      ready_comb = drop_rdy;
      sel_valid  = '0;
      sel_last   = '0;
      sel_data   = '0;
      sel_keep   = '0;
      for (int j = 0; j < M_CHANNEL_NO; j++) begin
         for (int i = 0; i < S_CHANNEL_NO; i++) begin
            if (grant[j] == GRANT_WIDTH'(i)) begin
               sel_valid[j] = s_axis_tvalid[i];
               sel_last[j]  = s_axis_tlast[i];
               sel_data[j]  = s_axis_tdata[i];
               sel_keep[j]  = s_axis_tkeep[i];
               if (busy[j] && out_rdy[j]) ready_comb[i] = 1'b1;
            end
         end
      end
   end

   assign s_axis_tready = areset ? ready_comb : '0;

   for (gj = 0; gj < M_CHANNEL_NO; gj++) begin : g_out
      logic                  valid_reg;
      logic                  last_reg;
      logic [DATA_WIDTH-1:0] data_reg;
      logic [KEEP_WIDTH-1:0] keep_reg;

      assign out_rdy[gj]    = !valid_reg || m_axis_tready[gj];
      assign arb_accept[gj] = busy[gj] && out_rdy[gj] && sel_valid[gj];

      cross_bar_rr_arbiter #(
         .CHANNEL_NO  (S_CHANNEL_NO),
         .GRANT_WIDTH (GRANT_WIDTH)
      ) u_arb (
         .aclk   (aclk),
         .areset (areset),
         .req    (req[gj]),
         .accept (arb_accept[gj]),
         .last   (sel_last[gj]),
         .grant  (grant[gj]),
         .busy   (busy[gj])
      );

      always_ff @(posedge aclk or negedge areset) begin
         if (!areset) begin
            valid_reg <= 1'b0;
            last_reg  <= 1'b0;
            data_reg  <= '0;
            keep_reg  <= '0;
         end else if (out_rdy[gj]) begin
            valid_reg <= arb_accept[gj];
            if (arb_accept[gj]) begin
               last_reg <= sel_last[gj];
               data_reg <= sel_data[gj];
               keep_reg <= sel_keep[gj];
            end
         end
      end

      assign m_axis_tvalid[gj] = valid_reg;
      assign m_axis_tlast[gj]  = last_reg;
      assign m_axis_tdata[gj]  = data_reg;
      assign m_axis_tkeep[gj]  = keep_reg;
   end

endmodule

// File: tb/tb_cross_bar_switch_tdest.sv
// Bench for cross_bar_switch_tdest: directed scenarios plus random traffic,
// checked against per-(output,input) packet queues and simple counters.
module tb_cross_bar_switch_tdest;

   localparam int S   = 4;
   localparam int M   = 3;
   localparam int DW  = 32;
   localparam int KW  = 4;
   localparam int DSW = 2;

   logic                 aclk = 1'b0;
   logic                 areset = 1'b1;
   logic [S-1:0][DW-1:0] s_tdata  = '0;
   logic [S-1:0][KW-1:0] s_tkeep  = '0;
   logic [S-1:0][DSW-1:0] s_tdest = '0;
   logic [S-1:0]         s_tvalid = '0;
   logic [S-1:0]         s_tlast  = '0;
   logic [S-1:0]         s_tready;
   logic [S-1:0]         s_drop;
   logic [M-1:0][DW-1:0] m_tdata;
   logic [M-1:0][KW-1:0] m_tkeep;
   logic [M-1:0]         m_tvalid;
   logic [M-1:0]         m_tlast;
   logic [M-1:0]         m_tready;

   cross_bar_switch_tdest #(
      .S_CHANNEL_NO (S),
      .M_CHANNEL_NO (M),
      .DATA_WIDTH   (DW)
   ) dut (
      .aclk          (aclk),
      .areset        (areset),
      .s_axis_tdata  (s_tdata),
      .s_axis_tkeep  (s_tkeep),
      .s_axis_tdest  (s_tdest),
      .s_axis_tvalid (s_tvalid),
      .s_axis_tlast  (s_tlast),
      .s_axis_tready (s_tready),
      .m_axis_tdata  (m_tdata),
      .m_axis_tkeep  (m_tkeep),
      .m_axis_tvalid (m_tvalid),
      .m_axis_tlast  (m_tlast),
      .m_axis_tready (m_tready),
      .s_drop        (s_drop)
   );

   initial forever #5 aclk = ~aclk;

   int cyc = 0;
   initial forever begin
      @(posedge aclk);
      cyc++;
   end

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Beat payload carries its source input in the top byte.
   function automatic logic [31:0] dat(input int i, input int pid, input int v);
      return {8'(i), 8'(pid), 8'h00, 8'(v)};
   endfunction

   function automatic logic [3:0] kp(input int v);
      return 4'(v) ^ 4'hA;
   endfunction

   // Reference model: expected {keep,last,data} per (output, input).
   logic [36:0] exp_q [M][S][$];
   int pkt_id [S];
   int exp_drop [S];

   function automatic int q_total();
      int t;
      t = 0;
      for (int j = 0; j < M; j++)
         for (int i = 0; i < S; i++) t += exp_q[j][i].size();
      return t;
   endfunction

   // Monitor state
   logic sb_en = 1'b1;
   int   vcnt [M];
   int   mb_cnt [M];
   int   first_v [M];
   int   last_v [M];
   int   acc_cnt [S];
   int   drop_cnt [S];
   logic in_pkt [M];
   int   cur_src [M];
   logic hold_v [M];
   logic [36:0] hold_d [M];
   int   rr_q [$];

   initial begin
      for (int j = 0; j < M; j++) begin
         vcnt[j] = 0; mb_cnt[j] = 0; first_v[j] = -1; last_v[j] = -1;
         in_pkt[j] = 1'b0; cur_src[j] = 0; hold_v[j] = 1'b0; hold_d[j] = '0;
      end
      for (int i = 0; i < S; i++) begin
         acc_cnt[i] = 0; drop_cnt[i] = 0; pkt_id[i] = 0; exp_drop[i] = 0;
      end
      forever begin
         @(negedge aclk);
         if (!areset) begin
            for (int j = 0; j < M; j++) begin
               in_pkt[j] = 1'b0;
               hold_v[j] = 1'b0;
            end
         end else begin
            for (int i = 0; i < S; i++) begin
               if (s_tvalid[i] && s_tready[i]) acc_cnt[i]++;
               if (s_drop[i]) drop_cnt[i]++;
            end
            for (int j = 0; j < M; j++) begin
               if (hold_v[j]) begin
                  chk("m_hold_valid", m_tvalid[j], 1);
                  chk("m_hold_data", {m_tkeep[j], m_tlast[j], m_tdata[j]}, hold_d[j]);
               end
               if (m_tvalid[j]) begin
                  vcnt[j]++;
                  if (first_v[j] < 0) first_v[j] = cyc;
                  last_v[j] = cyc;
               end
               hold_v[j] = m_tvalid[j] && !m_tready[j];
               hold_d[j] = {m_tkeep[j], m_tlast[j], m_tdata[j]};
               if (m_tvalid[j] && m_tready[j]) begin
                  mb_cnt[j]++;
                  if (sb_en) begin
                     int src;
                     logic [36:0] ent;
                     src = int'(m_tdata[j][31:24]);
                     if (in_pkt[j]) chk("m_interleave", src, cur_src[j]);
                     else if (j == 0) rr_q.push_back(src);
                     cur_src[j] = src;
                     chk("m_src_range", src < S, 1);
                     if (src < S) begin
                        chk("m_beat_expected", exp_q[j][src].size() > 0, 1);
                        if (exp_q[j][src].size() > 0) begin
                           ent = exp_q[j][src].pop_front();
                           chk("m_beat", {m_tkeep[j], m_tlast[j], m_tdata[j]}, ent);
                        end
                     end
                  end
                  in_pkt[j] = !m_tlast[j];
               end
            end
         end
      end
   end

   // Output ready pattern: 0 all ready, 1 toggle m1, 2 random.
   int rdy_mode = 0;
   initial begin
      m_tready = '1;
      forever begin
         @(posedge aclk);
         #1;
         case (rdy_mode)
            1: begin
               m_tready[0] = 1'b1;
               m_tready[2] = 1'b1;
               m_tready[1] = ~m_tready[1];
            end
            2: m_tready = 3'($urandom);
            default: m_tready = '1;
         endcase
      end
   end

   // Drives one beat and waits (bounded) for it to be accepted.
   task automatic put_beat(input int i, input logic [31:0] d, input logic [3:0] k,
                           input int dest, input logic last);
      int to;
      to = 0;
      s_tdata[i]  = d;
      s_tkeep[i]  = k;
      s_tdest[i]  = DSW'(dest);
      s_tlast[i]  = last;
      s_tvalid[i] = 1'b1;
      @(negedge aclk);
      while (!s_tready[i] && to < 1000) begin
         to++;
         @(negedge aclk);
      end
      chk("s_accept_timeout", to >= 1000, 0);
      @(posedge aclk);
      #1;
      s_tvalid[i] = 1'b0;
   endtask

   task automatic send_pkt(input int i, input int dh, input int dr, input int n,
                           input int base, input int gap_max);
      int pid;
      pid = pkt_id[i] & 8'hFF;
      pkt_id[i]++;
      if (dh < M) begin
         for (int b = 0; b < n; b++)
            exp_q[dh][i].push_back({kp(base + b), b == n - 1, dat(i, pid, base + b)});
      end else begin
         exp_drop[i]++;
      end
      for (int b = 0; b < n; b++) begin
         repeat ($urandom_range(gap_max, 0)) begin
            @(posedge aclk);
            #1;
         end
         put_beat(i, dat(i, pid, base + b), kp(base + b), (b == 0) ? dh : dr, b == n - 1);
      end
   endtask

   task automatic rand_stream(input int i);
      for (int p = 0; p < 6; p++)
         send_pkt(i, int'($urandom_range(3, 0)), int'($urandom_range(3, 0)),
                  int'($urandom_range(5, 1)), p * 16, 2);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0, n, v0, v1, v2, a0, d0;
      // Reset state, with a drop-eligible input held valid during reset
      #1 areset = 1'b0;
      s_tvalid[2] = 1'b1;
      s_tdest[2]  = 2'd3;
      repeat (3) @(posedge aclk);
      @(negedge aclk);
      chk("rst_m_tvalid", m_tvalid, 0);
      chk("rst_m_tdata", m_tdata, 0);
      chk("rst_s_tready", s_tready, 0);
      chk("rst_s_drop", s_drop, 0);
      s_tvalid[2] = 1'b0;
      s_tdest[2]  = '0;
      areset = 1'b1;
      @(posedge aclk);
      #1;

      // Single packet S0 -> m2, latency and data
      v0 = vcnt[0]; v1 = vcnt[1];
      c0 = cyc;
      fork
         send_pkt(0, 2, 2, 4, 8'hA0, 0);
         begin
            n = 0;
            @(negedge aclk);
            while (!m_tvalid[2] && n < 50) begin n++; @(negedge aclk); end
            chk("p1_latency", cyc - c0, 2);
            for (int k = 0; k < 4; k++) begin
               chk("p1_data", m_tdata[2], 32'h000000A0 + 32'(k));
               chk("p1_last", m_tlast[2], k == 3);
               @(negedge aclk);
            end
         end
      join
      repeat (3) @(posedge aclk);
      chk("p1_m0_idle", vcnt[0] - v0, 0);
      chk("p1_m1_idle", vcnt[1] - v1, 0);
      #1;

      // Round-robin fairness on m0
      rr_q.delete();
      first_v[0] = -1;
      v0 = vcnt[0];
      fork
         repeat (2) send_pkt(0, 0, 0, 2, 8'h10, 0);
         repeat (2) send_pkt(1, 0, 0, 2, 8'h10, 0);
         repeat (2) send_pkt(2, 0, 0, 2, 8'h10, 0);
         repeat (2) send_pkt(3, 0, 0, 2, 8'h10, 0);
      join
      repeat (5) @(posedge aclk);
      chk("rr_count", rr_q.size(), 8);
      for (int k = 0; k < rr_q.size(); k++) chk("rr_order", rr_q[k], k % 4);
      chk("rr_beats", vcnt[0] - v0, 16);
      chk("rr_span", last_v[0] - first_v[0] + 1, 23);
      #1;

      // Concurrency: S0 -> m0 and S1 -> m1
      first_v[0] = -1; first_v[1] = -1;
      v0 = vcnt[0]; v1 = vcnt[1];
      fork
         send_pkt(0, 0, 0, 8, 8'h20, 0);
         send_pkt(1, 1, 1, 8, 8'h30, 0);
      join
      repeat (4) @(posedge aclk);
      chk("cc_m0_beats", vcnt[0] - v0, 8);
      chk("cc_m1_beats", vcnt[1] - v1, 8);
      chk("cc_m0_span", last_v[0] - first_v[0] + 1, 8);
      chk("cc_m1_span", last_v[1] - first_v[1] + 1, 8);
      #1;

      // Drop: out-of-range tdest on S2
      v0 = vcnt[0] + vcnt[1] + vcnt[2];
      a0 = acc_cnt[2]; d0 = drop_cnt[2];
      send_pkt(2, 3, 3, 3, 8'h40, 0);
      repeat (4) @(posedge aclk);
      chk("drop_accepted", acc_cnt[2] - a0, 3);
      chk("drop_pulses", drop_cnt[2] - d0, 1);
      chk("drop_no_output", vcnt[0] + vcnt[1] + vcnt[2] - v0, 0);
      #1;

      // Backpressure on m1 with tdest changing after the head beat
      v0 = mb_cnt[0]; v1 = mb_cnt[1];
      rdy_mode = 1;
      send_pkt(0, 1, 0, 6, 8'h50, 0);
      repeat (10) @(posedge aclk);
      rdy_mode = 0;
      repeat (2) @(posedge aclk);
      chk("bp_m1_beats", mb_cnt[1] - v1, 6);
      chk("bp_m0_beats", mb_cnt[0] - v0, 0);
      chk("bp_queue_empty", exp_q[1][0].size(), 0);
      #1;

      // Reset in the middle of a 5-beat S0 -> m2 packet
      sb_en = 1'b0;
      put_beat(0, dat(0, 8'h66, 0), kp(0), 2, 1'b0);
      put_beat(0, dat(0, 8'h66, 1), kp(1), 2, 1'b0);
      s_tdata[0] = dat(0, 8'h66, 2); s_tdest[0] = 2'd2; s_tlast[0] = 1'b0;
      s_tvalid[0] = 1'b1;
      #1;
      chk("mr_before_valid", m_tvalid[2], 1);
      areset = 1'b0;
      #1;
      chk("mr_m_tvalid", m_tvalid, 0);
      chk("mr_m_tdata", m_tdata, 0);
      chk("mr_s_tready", s_tready, 0);
      s_tvalid[0] = 1'b0;
      repeat (2) @(posedge aclk);
      @(negedge aclk);
      areset = 1'b1;
      v2 = vcnt[2];
      @(posedge aclk);
      #1;
      put_beat(0, dat(0, 8'h77, 8'h99), kp(3), 1, 1'b1);
      n = 0;
      @(negedge aclk);
      while (!m_tvalid[1] && n < 20) begin n++; @(negedge aclk); end
      chk("mr_head_routed", m_tvalid[1], 1);
      chk("mr_head_data", m_tdata[1], dat(0, 8'h77, 8'h99));
      chk("mr_m2_quiet", vcnt[2] - v2, 0);
      repeat (2) @(posedge aclk);
      #1;
      sb_en = 1'b1;

      // Random traffic with random output backpressure
      rdy_mode = 2;
      fork
         rand_stream(0);
         rand_stream(1);
         rand_stream(2);
         rand_stream(3);
      join
      rdy_mode = 0;
      n = 0;
      while (q_total() != 0 && n < 500) begin @(negedge aclk); n++; end
      chk("rand_drained", q_total(), 0);
      repeat (3) @(posedge aclk);
      for (int i = 0; i < S; i++) chk("drop_total", drop_cnt[i], exp_drop[i]);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/cross_bar_switch_tdest.md
Name: cross_bar_switch_tdest

Overview:
- Parametrised successor to the fixed-power-of-two crossbar: S-input, M-output AXI-Stream switch routed by tdest.
- Each output has a packet-level round-robin arbiter and a registered output stage.
- Arbitrary, non-power-of-two channel counts are supported.
- Packets whose tdest is out of range are consumed and dropped, with a status pulse.
- Sits between ingress stream sources and egress sinks, for example port-to-queue fabrics.

Parameters:
- S_CHANNEL_NO, 4: number of slave (input) ports, 1..32.
- M_CHANNEL_NO, 3: number of master (output) ports, 1..32.
- DATA_WIDTH, 32: tdata width, a multiple of 8.
- KEEP_WIDTH, DATA_WIDTH/8: tkeep width, derived.
- DEST_WIDTH, max(1,$clog2(M_CHANNEL_NO)): tdest width, derived.

Ports:
- aclk  in  1  clock; all logic is rising-edge.
- areset  in  1  asynchronous, active-low reset.
- s_axis_tdata[S]  in  DATA_WIDTH  input data.
- s_axis_tkeep[S]  in  KEEP_WIDTH  byte enables, passed through.
- s_axis_tdest[S]  in  DEST_WIDTH  destination output index; sampled on the head beat only.
- s_axis_tvalid[S]  in  1  input valid.
- s_axis_tlast[S]  in  1  end of packet.
- s_axis_tready[S]  out  1  input ready.
- m_axis_tdata[M]  out  DATA_WIDTH  output data.
- m_axis_tkeep[M]  out  KEEP_WIDTH  output byte enables.
- m_axis_tvalid[M]  out  1  output valid.
- m_axis_tlast[M]  out  1  output end of packet.
- m_axis_tready[M]  in  1  output ready.
- s_drop[S]  out  1  one-cycle pulse on acceptance of the head beat of a dropped packet.

Behaviour:
- Reset (areset=0, asynchronous):
  - All m_axis_tvalid=0, m_axis_tdata/tkeep/tlast=0, s_drop=0, s_axis_tready=0.
  - All arbiters go IDLE; rr pointers go to 0.
  - Every input head flag is set to 1.
  - A packet in flight is abandoned with no flush; the first beat after reset is treated as a head.
- Input route tracking, per input i:
  - A head flag marks the next beat as a packet head.
  - On head-beat acceptance, dest[i] latches s_axis_tdest[i]; the head flag clears and sets again after a tlast beat is accepted.
  - Effective dest is s_axis_tdest on a head beat and the latched dest otherwise.
  - Request req[j][i] = tvalid & (effective dest == j) & (dest < M_CHANNEL_NO).
- Drop, when effective dest >= M_CHANNEL_NO:
  - s_axis_tready[i]=1 for the whole packet; beats are discarded.
  - s_drop[i] pulses for one cycle on the head beat.
- Arbiter, per output j, FSM IDLE/BUSY with registered grant:
  - IDLE: if any req[j], select the first requester at or after ptr[j] in cyclic order; register grant[j]; go BUSY next cycle.
  - BUSY: s_axis_tready[grant] = out_rdy[j]; the selected beat loads the output register.
  - On a tlast beat accepted: go IDLE; ptr[j] = grant+1, wrapping to 0 at S_CHANNEL_NO.
  - A grant is held for the whole packet, even if the input stalls mid-packet (tvalid=0); no preemption.
  - Non-granted inputs see tready=0.
- Output register, per output:
  - out_rdy = !m_axis_tvalid | m_axis_tready, giving full throughput.
  - When out_rdy and no new beat, m_axis_tvalid clears.
- Latency and throughput:
  - Head beat presented at cycle 0: grant in cycle 1, accepted at the end of cycle 1, m_axis_tvalid at cycle 2.
  - Then one beat per cycle.
  - One idle cycle per output between consecutive packets.
- Simultaneous events:
  - Multiple outputs serve different inputs concurrently.
  - An input only ever requests one output: strict head-of-line.
  - All requesters equal: rotation 0,1,..,S-1.
  - A single-beat packet (head and tlast together) is legal.
- Backpressure: with m_axis_tready=0 and m_axis_tvalid=1, data is held stable and no input beat is accepted on that output.

Decomposition:
- Package cross_bar_pkg holds:
  - clog2-safe width function (returns at least 1).
  - Arbiter state enum {ARB_IDLE, ARB_BUSY}.
  - Channel-count limit constants.
- One sub-module, cross_bar_rr_arbiter: round-robin grant plus the IDLE/BUSY FSM.
  - Parameter CHANNEL_NO.
  - Inputs: req vector, accept, last.
  - Outputs: grant index, busy.
- The top instantiates one arbiter per output, plus per-input head/dest logic and output muxes.

Test Plan:
- Single packet: S0 sends a 4-beat packet, tdest=2, data 0xA0..0xA3, all ready → m2 emits 0xA0..0xA3 with tlast on the 4th beat; first m2 tvalid 2 cycles after s0 head tvalid; other outputs stay idle.
- Round-robin fairness: S0..S3 each continuously send 2-beat packets to m0 → m0 packet order 0,1,2,3,0,…; one idle cycle between packets; each input receives 25% of packets.
- Concurrency: S0→m0 and S1→m1, 8 beats each, simultaneously → both outputs stream at one beat per cycle with no interleaving.
- Drop: S2 sends tdest=3 with M=3 (out of range), a 3-beat packet → s_axis_tready[2]=1 for 3 cycles; s_drop[2] pulses once; no m_axis_tvalid.
- Backpressure and mid-packet dest change: m1 tready toggles 1010…; S0 packet has tdest=1 on the head beat and 0 on later beats → all beats go to m1; data stable while stalled; no beat lost or duplicated.
- Reset mid-packet: areset low during beat 2 of 5 → all outputs go to 0 immediately; after release, S0's next beat is treated as a head and routed by its own tdest.
